// File: rtl/aha_sys_reset_sequencer_if.sv
// aha_sys_reset_sequencer_if: request/quiesce handshake and staged domain resets of the warm-reset sequencer.
interface aha_sys_reset_sequencer_if #(parameter int NUM_DOMAINS = 4);
  logic                   SYSRESETREQ;
  logic                   QUIESCE_REQ;
  logic                   QUIESCE_ACK;
  logic [NUM_DOMAINS-1:0] DOMAIN_RESETn;
  logic                   RESET_ACTIVE;
  logic [7:0]             RESET_COUNT;
  logic                   QTIMEOUT_FLAG;
  modport master (
    input  SYSRESETREQ, QUIESCE_ACK,
    output QUIESCE_REQ, DOMAIN_RESETn, RESET_ACTIVE, RESET_COUNT, QTIMEOUT_FLAG
  );
  modport slave (
    output SYSRESETREQ, QUIESCE_ACK,
    input  QUIESCE_REQ, DOMAIN_RESETn, RESET_ACTIVE, RESET_COUNT, QTIMEOUT_FLAG
  );
endinterface

// File: rtl/aha_sys_reset_sequencer.sv
// aha_sys_reset_sequencer: quiesce handshake, fixed hold, then staged per-domain reset release.
// Define AHA_RST_SEQ_QTIMEOUT_EN to force HOLD when QUIESCE_ACK never arrives.
module aha_sys_reset_sequencer #(
  parameter int NUM_DOMAINS     = 4,
  parameter int HOLD_CYCLES     = 16,
  parameter int STAGE_GAP       = 4,
  parameter int QTIMEOUT_CYCLES = 64
) (
  input logic CLK,
  input logic RESET,
  aha_sys_reset_sequencer_if.master rsq
);
  typedef enum logic [1:0] {IDLE, QUIESCE, HOLD, RELEASE} state_t;
  state_t                 state, state_n;
  logic [15:0]            cnt, cnt_n;
  logic [3:0]             idx, idx_n;
  logic [NUM_DOMAINS-1:0] dom, dom_n;
  logic                   qreq, qreq_n;
  logic [7:0]             rcnt, rcnt_n;
`ifdef AHA_RST_SEQ_QTIMEOUT_EN
  logic                   qto, qto_n;
`endif
  always_comb begin
    state_n = state;
    cnt_n   = cnt + 16'd1;
    idx_n   = idx;
    dom_n   = dom;
    qreq_n  = qreq;
    rcnt_n  = rcnt;
`ifdef AHA_RST_SEQ_QTIMEOUT_EN
    qto_n   = qto;
`endif
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (rsq.SYSRESETREQ) begin
          state_n = QUIESCE;
          qreq_n  = 1'b1;
          rcnt_n  = rcnt == 8'hff ? rcnt : rcnt + 8'd1;
        end
      end
      QUIESCE: begin
`ifdef AHA_RST_SEQ_QTIMEOUT_EN
        if (rsq.QUIESCE_ACK || cnt == 16'(QTIMEOUT_CYCLES - 1)) begin
          state_n = HOLD;
          dom_n   = '0;
          qreq_n  = 1'b0;
          cnt_n   = '0;
          qto_n   = qto | !rsq.QUIESCE_ACK;
        end
`else
        cnt_n = '0;
        if (rsq.QUIESCE_ACK) begin
          state_n = HOLD;
          dom_n   = '0;
          qreq_n  = 1'b0;
        end
`endif
      end
      HOLD: begin
        if (cnt == 16'(HOLD_CYCLES - 1)) begin
          state_n = NUM_DOMAINS == 1 ? IDLE : RELEASE;
          dom_n   = NUM_DOMAINS'(1);
          idx_n   = 4'd1;
          cnt_n   = '0;
        end
      end
      default: begin
        if (cnt == 16'(STAGE_GAP - 1)) begin
          dom_n   = dom | (NUM_DOMAINS'(1) << idx);
          idx_n   = idx + 4'd1;
          cnt_n   = '0;
          state_n = idx == 4'(NUM_DOMAINS - 1) ? IDLE : RELEASE;
        end
      end
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= HOLD;
      cnt   <= '0;
      idx   <= '0;
      dom   <= '0;
      qreq  <= 1'b0;
      rcnt  <= '0;
`ifdef AHA_RST_SEQ_QTIMEOUT_EN
      qto   <= 1'b0;
`endif
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      dom   <= dom_n;
      qreq  <= qreq_n;
      rcnt  <= rcnt_n;
`ifdef AHA_RST_SEQ_QTIMEOUT_EN
      qto   <= qto_n;
`endif
    end
  end
  assign rsq.QUIESCE_REQ   = qreq;
  assign rsq.DOMAIN_RESETn = dom;
  assign rsq.RESET_ACTIVE  = state != IDLE;
  assign rsq.RESET_COUNT   = rcnt;
`ifdef AHA_RST_SEQ_QTIMEOUT_EN
  assign rsq.QTIMEOUT_FLAG = qto;
`else
  assign rsq.QTIMEOUT_FLAG = 1'b0;
`endif
endmodule
